jtag_tap_bsr: RTL and testbench
===============================

# jtag_tap_bsr

Parametrised IEEE 1149.1 TAP controller with an integrated boundary-scan register (BSR) of configurable length and a configurable instruction-register width. It is the next generation of the team's JTAG test logic: the boundary-scan chain moves in-block (no external `bsr_*` strobes), IDCODE/SAMPLE/EXTEST are supported, and an optional user data register is available. It sits between the Tiny Tapeout top-level pins and the core's I/O, driven by the scan clock.

## Interface

Parameters:
- `IR_WIDTH`, 4, instruction register width in bits; minimum 2
- `BSR_LEN`, 8, number of boundary-scan cells; minimum 1
- `IDCODE`, 32'h1000_563F, device ID value; bit 0 must be 1
- `USER_WIDTH`, 16, user DR width; used only when `JTAG_USERDR_EN` is defined

Ports:
- `clk` in 1: scan clock (TCK); all state changes on rising edge
- `rst` in 1: synchronous, active-high reset
- `tms` in 1: test mode select, sampled on rising `clk`
- `tdi` in 1: test data in, sampled on rising `clk`
- `tdo` out 1: test data out
- `tdo_oe` out 1: high in Shift-IR/Shift-DR
- `sys_in` in BSR_LEN: core-side values observed by BSR cells
- `pad_out` out BSR_LEN: values driven to pins
- `bsr_mode` out 1: high while EXTEST is the active instruction
- `ir_out` out IR_WIDTH: active (updated) instruction
- `tap_state` out 4: current FSM state encoding
- `tlr` out 1: high while in Test-Logic-Reset
- `user_in` in USER_WIDTH, `user_out` out USER_WIDTH, `user_upd` out 1: present only with `JTAG_USERDR_EN`

## Operation

- FSM: the 16 standard states; encodings 0 TLR, 1 RTI, 2 SelDR, 3 CapDR, 4 ShDR, 5 Ex1DR, 6 PauseDR, 7 Ex2DR, 8 UpdDR, 9 SelIR, 10 CapIR, 11 ShIR, 12 Ex1IR, 13 PauseIR, 14 Ex2IR, 15 UpdIR. Transitions follow 1149.1 exactly on `tms`.
- Instructions: EXTEST = 0, IDCODE = 1, SAMPLE/PRELOAD = 2, USER = 3 (with the macro), BYPASS = all ones. Any other code (including 3 without the macro) selects BYPASS.
- Action on the rising edge while in a state:
  - CapIR: IR shift register loads `{0..0,01}`.
  - ShIR/ShDR: the selected shift register shifts right; `tdi` enters the MSB.
  - UpdIR: `ir_out` loads the IR shift register.
  - CapDR: IDCODE loads `IDCODE`; BYPASS loads 0; SAMPLE/EXTEST load BSR from `sys_in`; USER loads from `user_in`.
  - UpdDR: for SAMPLE/EXTEST, the BSR update latch loads the BSR shift register; for USER, `user_out` loads and `user_upd` pulses.
  - TLR: `ir_out` is forced to IDCODE.
- `tdo` is combinational: the LSB of the selected shift register while in ShIR/ShDR, otherwise 0.
- `pad_out` equals the update latch when `bsr_mode` is 1, else `sys_in`.

## Timing

- Reset values: state TLR, `ir_out` = IDCODE, shift registers 0, update latch 0, `tdo` 0, `tdo_oe` 0, `bsr_mode` 0, `tlr` 1, `pad_out` = `sys_in`, `user_out` 0, `user_upd` 0.
- `rst` takes effect at the next edge and overrides all activity, including mid-shift.
- Five consecutive `tms`=1 edges from any state reach TLR.
- BYPASS gives a one-cycle `tdi`→`tdo` latency; IDCODE shifts out 32 bits LSB first, followed by `tdi` data.
- `user_upd` is high for exactly the one cycle following the UpdDR edge.
- Pause states hold all registers unchanged.
- `bsr_mode` and `pad_out` change the cycle after the UpdIR/UpdDR edge.

## Configuration

- `JTAG_USERDR_EN` defined: the USER instruction, the `user_*` ports, and a USER_WIDTH shift and update register are present.
- Not defined: the ports and logic are absent, and code 3 decodes as BYPASS.

## Test plan

- `rst` high for 1 cycle → `tap_state`=0, `ir_out`=4'h1, `tlr`=1, `tdo_oe`=0. Then enter ShDR and apply five `tms`=1 → `tap_state`=0.
- From TLR, apply `tms` 0,1,0,0 and shift 32 bits → `tdo` sequence equals 32'h1000_563F LSB first.
- Shift IR: the first 4 `tdo` bits read 1,0,0,0. Load 4'hF, shift DR `tdi` 1,0,1,1 → `tdo` 0,1,0,1,1.
- SAMPLE with `sys_in`=8'h3C → 8 DR shifts read 0x3C LSB first. Preload 8'hA5, then EXTEST → `bsr_mode`=1, `pad_out`=8'hA5.
- Assert `rst` mid-ShDR of a preloaded EXTEST → next cycle `pad_out`=`sys_in`, `bsr_mode`=0.
- With `JTAG_USERDR_EN`: IR=3, shift 16'hBEEF, UpdDR → `user_out`=16'hBEEF and a one-cycle `user_upd`.

Source files
------------

// File: rtl/jtag_tap_bsr_if.sv
// Serial scan pins of the TAP: TMS/TDI in, TDO with its output enable out.
interface jtag_tap_bsr_if;
  logic tms;
  logic tdi;
  logic tdo;
  logic tdo_oe;

  modport master (output tms, output tdi, input tdo, input tdo_oe);
  modport slave  (input tms, input tdi, output tdo, output tdo_oe);
endinterface

// File: rtl/jtag_tap_bsr.sv
// IEEE 1149.1 TAP controller with in-block boundary-scan register, IDCODE/SAMPLE/EXTEST/BYPASS.
// Define JTAG_USERDR_EN to add the USER instruction (code 3) and its data/update register.
module jtag_tap_bsr #(
  parameter int          IR_WIDTH   = 4,
  parameter int          BSR_LEN    = 8,
  parameter logic [31:0] IDCODE     = 32'h1000_563F,
  parameter int          USER_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  jtag_tap_bsr_if.slave         jtag,
  input  logic [BSR_LEN-1:0]    sys_in,
  output logic [BSR_LEN-1:0]    pad_out,
  output logic                  bsr_mode,
  output logic [IR_WIDTH-1:0]   ir_out,
  output logic [3:0]            tap_state,
  output logic                  tlr
`ifdef JTAG_USERDR_EN
  ,
  input  logic [USER_WIDTH-1:0] user_in,
  output logic [USER_WIDTH-1:0] user_out,
  output logic                  user_upd
`endif
);

  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PAUSEDR, EX2DR,
    UPDDR, SELIR, CAPIR, SHIR, EX1IR, PAUSEIR, EX2IR, UPDIR
  } state_e;

  typedef enum logic [2:0] {
    SEL_EXTEST, SEL_IDCODE, SEL_SAMPLE, SEL_USER, SEL_BYPASS
  } sel_e;

  localparam logic [IR_WIDTH-1:0] INS_EXTEST = IR_WIDTH'(0);
  localparam logic [IR_WIDTH-1:0] INS_IDCODE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] INS_SAMPLE = IR_WIDTH'(2);

  state_e               r_state, w_next;
  sel_e                 w_sel;
  logic [IR_WIDTH-1:0]  r_ir_sr, r_ir;
  logic [31:0]          r_id_sr;
  logic                 r_byp;
  logic [BSR_LEN-1:0]   r_bsr_sr, r_bsr_upd;
  logic                 w_tdo;
`ifdef JTAG_USERDR_EN
  logic [USER_WIDTH-1:0] r_user_sr, r_user_out;
  logic                  r_user_upd;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= TLR;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      TLR:     w_next = jtag.tms ? TLR   : RTI;
      RTI:     w_next = jtag.tms ? SELDR : RTI;
      SELDR:   w_next = jtag.tms ? SELIR : CAPDR;
      CAPDR:   w_next = jtag.tms ? EX1DR : SHDR;
      SHDR:    w_next = jtag.tms ? EX1DR : SHDR;
      EX1DR:   w_next = jtag.tms ? UPDDR : PAUSEDR;
      PAUSEDR: w_next = jtag.tms ? EX2DR : PAUSEDR;
      EX2DR:   w_next = jtag.tms ? UPDDR : SHDR;
      UPDDR:   w_next = jtag.tms ? SELDR : RTI;
      SELIR:   w_next = jtag.tms ? TLR   : CAPIR;
      CAPIR:   w_next = jtag.tms ? EX1IR : SHIR;
      SHIR:    w_next = jtag.tms ? EX1IR : SHIR;
      EX1IR:   w_next = jtag.tms ? UPDIR : PAUSEIR;
      PAUSEIR: w_next = jtag.tms ? EX2IR : PAUSEIR;
      EX2IR:   w_next = jtag.tms ? UPDIR : SHIR;
      UPDIR:   w_next = jtag.tms ? SELDR : RTI;
      default: w_next = TLR;
    endcase
  end

  // Unlisted codes (and code 3 without the user register) fall through to BYPASS.
  always_comb begin
    w_sel = SEL_BYPASS;
    if      (r_ir == INS_EXTEST) w_sel = SEL_EXTEST;
    else if (r_ir == INS_IDCODE) w_sel = SEL_IDCODE;
    else if (r_ir == INS_SAMPLE) w_sel = SEL_SAMPLE;
`ifdef JTAG_USERDR_EN
    else if (r_ir == IR_WIDTH'(3)) w_sel = SEL_USER;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir_sr <= '0;
      r_ir    <= INS_IDCODE;
    end else begin
      case (r_state)
        TLR:     r_ir    <= INS_IDCODE;
        CAPIR:   r_ir_sr <= IR_WIDTH'(1);
        SHIR:    r_ir_sr <= IR_WIDTH'({jtag.tdi, r_ir_sr} >> 1);
        UPDIR:   r_ir    <= r_ir_sr;
        default: ;
      endcase
    end
  end

  // Shifts use a concatenate-and-shift form so a 1-bit register needs no special case.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_sr   <= '0;
      r_byp     <= 1'b0;
      r_bsr_sr  <= '0;
      r_bsr_upd <= '0;
    end else begin
      case (r_state)
        CAPDR: begin
          case (w_sel)
            SEL_IDCODE:            r_id_sr  <= IDCODE;
            SEL_SAMPLE, SEL_EXTEST: r_bsr_sr <= sys_in;
            SEL_BYPASS:            r_byp    <= 1'b0;
            default: ;
          endcase
        end
        SHDR: begin
          case (w_sel)
            SEL_IDCODE:            r_id_sr  <= {jtag.tdi, r_id_sr[31:1]};
            SEL_SAMPLE, SEL_EXTEST: r_bsr_sr <= BSR_LEN'({jtag.tdi, r_bsr_sr} >> 1);
            SEL_BYPASS:            r_byp    <= jtag.tdi;
            default: ;
          endcase
        end
        UPDDR: begin
          if (w_sel == SEL_SAMPLE || w_sel == SEL_EXTEST) r_bsr_upd <= r_bsr_sr;
        end
        default: ;
      endcase
    end
  end

`ifdef JTAG_USERDR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_user_sr  <= '0;
      r_user_out <= '0;
      r_user_upd <= 1'b0;
    end else begin
      r_user_upd <= 1'b0;
      if (w_sel == SEL_USER) begin
        case (r_state)
          CAPDR: r_user_sr <= user_in;
          SHDR:  r_user_sr <= USER_WIDTH'({jtag.tdi, r_user_sr} >> 1);
          UPDDR: begin
            r_user_out <= r_user_sr;
            r_user_upd <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign user_out = r_user_out;
  assign user_upd = r_user_upd;
`endif

  always_comb begin
    w_tdo = 1'b0;
    if (r_state == SHIR) begin
      w_tdo = r_ir_sr[0];
    end else if (r_state == SHDR) begin
      case (w_sel)
        SEL_IDCODE:            w_tdo = r_id_sr[0];
        SEL_SAMPLE, SEL_EXTEST: w_tdo = r_bsr_sr[0];
`ifdef JTAG_USERDR_EN
        SEL_USER:              w_tdo = r_user_sr[0];
`endif
        default:               w_tdo = r_byp;
      endcase
    end
  end

  assign jtag.tdo    = w_tdo;
  assign jtag.tdo_oe = (r_state == SHIR) || (r_state == SHDR);
  assign bsr_mode    = (r_ir == INS_EXTEST);
  assign pad_out     = bsr_mode ? r_bsr_upd : sys_in;
  assign ir_out      = r_ir;
  assign tap_state   = r_state;
  assign tlr         = (r_state == TLR);

endmodule

// File: tb/tb_jtag_tap_bsr.sv
// Directed bench for jtag_tap_bsr: queue-based scan model checked every cycle plus literal expectations.
module tb_jtag_tap_bsr;
  localparam int          IRW = 4;
  localparam int          BL  = 8;
  localparam int          UW  = 16;
  localparam logic [31:0] IDC = 32'h1000_563F;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtag_tap_bsr_if jt();
  logic [BL-1:0]  sys_in, pad_out;
  logic           bsr_mode, tlr;
  logic [IRW-1:0] ir_out;
  logic [3:0]     tap_state;
`ifdef JTAG_USERDR_EN
  logic [UW-1:0]  user_in, user_out;
  logic           user_upd;
`endif

  jtag_tap_bsr #(.IR_WIDTH(IRW), .BSR_LEN(BL), .IDCODE(IDC), .USER_WIDTH(UW)) dut (
    .clk(clk), .rst(rst), .jtag(jt),
    .sys_in(sys_in), .pad_out(pad_out), .bsr_mode(bsr_mode),
    .ir_out(ir_out), .tap_state(tap_state), .tlr(tlr)
`ifdef JTAG_USERDR_EN
    , .user_in(user_in), .user_out(user_out), .user_upd(user_upd)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Model: state via the 1149.1 transition table; each shift path is a bit queue
  // (front = bit presented on TDO, back = where TDI enters).
  int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2,  0, 12, 12, 15, 14, 15, 2};

  bit             m_valid = 1'b0;
  int             m_state;
  logic [IRW-1:0] m_ir;
  bit             m_irq[$];
  bit             m_drq[$];
  logic [BL-1:0]  m_latch;
  logic [UW-1:0]  m_uout;
  bit             m_uupd;

  // 0 EXTEST, 1 IDCODE, 2 SAMPLE, 3 USER, 4 BYPASS
  function automatic int sel_of(input logic [IRW-1:0] ir);
    if (ir == 0) return 0;
    if (ir == 1) return 1;
    if (ir == 2) return 2;
`ifdef JTAG_USERDR_EN
    if (ir == 3) return 3;
`endif
    return 4;
  endfunction

  function automatic logic [63:0] qval(input bit q[$]);
    logic [63:0] v = '0;
    foreach (q[i]) v[i] = q[i];
    return v;
  endfunction

  task automatic qload(inout bit q[$], input logic [63:0] v, input int n);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(v[i]);
  endtask

  always @(posedge clk) begin
    int s;
    logic [63:0] v;
    if (rst) begin
      m_valid = 1'b1;
      m_state = 0;
      m_ir    = 1;
      m_irq.delete();
      m_drq.delete();
      m_latch = '0;
      m_uout  = '0;
      m_uupd  = 1'b0;
    end else begin
      m_uupd = 1'b0;
      s = sel_of(m_ir);
      case (m_state)
        0:  m_ir = 1;
        10: qload(m_irq, 64'd1, IRW);
        11: begin void'(m_irq.pop_front()); m_irq.push_back(jt.tdi); end
        15: begin v = qval(m_irq); m_ir = v[IRW-1:0]; end
        3: begin
          if (s == 1)                qload(m_drq, {32'd0, IDC}, 32);
          else if (s == 0 || s == 2) qload(m_drq, {56'd0, sys_in}, BL);
`ifdef JTAG_USERDR_EN
          else if (s == 3)           qload(m_drq, {48'd0, user_in}, UW);
`endif
          else                       qload(m_drq, 64'd0, 1);
        end
        4: begin void'(m_drq.pop_front()); m_drq.push_back(jt.tdi); end
        8: begin
          v = qval(m_drq);
          if (s == 0 || s == 2) m_latch = v[BL-1:0];
          if (s == 3) begin m_uout = v[UW-1:0]; m_uupd = 1'b1; end
        end
        default: ;
      endcase
      m_state = jt.tms ? nxt1[m_state] : nxt0[m_state];
    end
  end

  always @(negedge clk) begin
    bit            e_tdo;
    logic [BL-1:0] e_pad;
    if (m_valid) begin
      e_tdo = 1'b0;
      if (m_state == 11)     e_tdo = m_irq[0];
      else if (m_state == 4) e_tdo = m_drq[0];
      e_pad = (m_ir == 0) ? m_latch : sys_in;
      chk("m_tap_state", tap_state, m_state);
      chk("m_tlr", tlr, m_state == 0);
      chk("m_tdo_oe", jt.tdo_oe, (m_state == 4) || (m_state == 11));
      chk("m_tdo", jt.tdo, e_tdo);
      chk("m_ir_out", ir_out, m_ir);
      chk("m_bsr_mode", bsr_mode, m_ir == 0);
      chk("m_pad_out", pad_out, e_pad);
`ifdef JTAG_USERDR_EN
      chk("m_user_out", user_out, m_uout);
      chk("m_user_upd", user_upd, m_uupd);
`endif
    end
  end

  task automatic tick(input bit t, input bit d);
    jt.tms = t;
    jt.tdi = d;
    @(posedge clk);
    #1;
  endtask

  // From RTI: load an instruction, returning the bits that came out on TDO.
  task automatic shift_ir(input logic [IRW-1:0] val, output logic [IRW-1:0] rd);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < IRW; i++) begin
      rd[i] = jt.tdo;
      tick(i == IRW - 1, val[i]);
    end
    tick(1, 0); tick(0, 0);
  endtask

  // From RTI: capture/shift n DR bits/update, back in RTI one cycle after the update edge.
  task automatic shift_dr(input logic [63:0] din, input int n, output logic [63:0] dout);
    dout = '0;
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < n; i++) begin
      dout[i] = jt.tdo;
      tick(i == n - 1, din[i]);
    end
    tick(1, 0); tick(0, 0);
  endtask

  initial begin
    logic [IRW-1:0] rd;
    logic [63:0]    dout;
    logic [31:0]    id;
    jt.tms = 1'b1; jt.tdi = 1'b0; sys_in = 8'h5A;
`ifdef JTAG_USERDR_EN
    user_in = 16'h1234;
`endif
    rst = 1'b1;
    tick(1, 0); tick(1, 0);
    rst = 1'b0;
    chk("rst_tap_state", tap_state, 0);
    chk("rst_ir_out", ir_out, 4'h1);
    chk("rst_tlr", tlr, 1);
    chk("rst_tdo_oe", jt.tdo_oe, 0);
    chk("rst_pad_out", pad_out, 8'h5A);

    tick(0, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    chk("in_shdr", tap_state, 4);
    for (int i = 0; i < 5; i++) tick(1, 0);
    chk("five_tms_tlr", tap_state, 0);

    tick(0, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 32; i++) begin
      id[i] = jt.tdo;
      tick(i == 31, 0);
    end
    chk("idcode_read", id, 32'h1000_563F);
    tick(1, 0); tick(0, 0);

    shift_ir(4'hF, rd);
    chk("ir_capture_bits", rd, 4'b0001);
    shift_dr(64'h0D, 5, dout);
    chk("bypass_seq", dout, 64'h1A);

    sys_in = 8'h3C;
    shift_ir(4'h2, rd);
    shift_dr(64'hA5, 8, dout);
    chk("sample_read", dout, 64'h3C);
    chk("sample_pad", pad_out, 8'h3C);
    shift_ir(4'h0, rd);
    chk("extest_mode", bsr_mode, 1);
    chk("extest_pad", pad_out, 8'hA5);

    tick(1, 0); tick(0, 0); tick(0, 0);
    tick(0, 1); tick(0, 0); tick(1, 1);
    tick(0, 0); tick(0, 1); tick(0, 0);
    chk("pause_pad_hold", pad_out, 8'hA5);
    tick(1, 0); tick(0, 0); tick(0, 1);
    rst = 1'b1;
    tick(0, 1);
    rst = 1'b0;
    chk("midshift_rst_pad", pad_out, 8'h3C);
    chk("midshift_rst_mode", bsr_mode, 0);
    chk("midshift_rst_state", tap_state, 0);

    for (int i = 0; i < 400; i++) begin
      if (i % 17 == 0) sys_in = 8'($urandom);
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 5; i++) tick(1, 0);
    tick(0, 0);
`ifdef JTAG_USERDR_EN
    shift_ir(4'h3, rd);
    shift_dr(64'hBEEF, 16, dout);
    chk("user_capture", dout, 64'h1234);
    chk("user_out", user_out, 16'hBEEF);
    chk("user_upd_high", user_upd, 1);
    tick(0, 0);
    chk("user_upd_low", user_upd, 0);
`else
    shift_ir(4'h3, rd);
    shift_dr(64'h1, 2, dout);
    chk("code3_bypass", dout, 64'h2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
